// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// rom_loader_pkg : state encoding and handshake constants shared with the
//                  ROM-loader model. Rev 1.0
// ============================================================================
package rom_loader_pkg;

  localparam int ROM_DATA_WIDTH   = 16;
  localparam int ROM_SETUP_CYCLES = 4;
  localparam int ROM_ACK_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_STROBE   = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, search starts one past
//              the last granted index. Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_loader_arbiter.sv
`default_nettype none
// ============================================================================
// rom_loader_arbiter : grants whole ROM-loader sessions to one of NUM_REQ
//                      word-stream requesters and runs the load/sck/ack
//                      handshake. Rev 1.0
// ============================================================================
module rom_loader_arbiter
  import rom_loader_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = ROM_DATA_WIDTH,
  parameter int MAX_WORDS    = 32768,
  parameter int ACK_TIMEOUT  = ROM_ACK_TIMEOUT,
  parameter int SETUP_CYCLES = ROM_SETUP_CYCLES,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_WORDS + 1),
  localparam int TW = $clog2(ACK_TIMEOUT + 1),
  localparam int SW = $clog2(SETUP_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [NUM_REQ-1:0]            wr_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_REQ-1:0]            wr_last_i,
  output logic [NUM_REQ-1:0]            wr_ready_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          error_o,
  output logic                          busy_o,
  output logic [CW-1:0]                 word_count_o,
  output logic                          rom_loader_load_o,
  output logic [DATA_WIDTH-1:0]         rom_loader_data_o,
  output logic                          rom_loader_sck_o,
  input  logic                          rom_loader_ack_i
);

  state_t                 state_q, state_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     wr_ready_q, wr_ready_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic [CW-1:0]          word_count_q, word_count_d;
  logic                   load_q, load_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   sck_q, sck_d;
  logic                   last_q, last_d;
  logic [SW-1:0]          setup_q, setup_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic [DATA_WIDTH-1:0]  words [NUM_REQ];
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i  (req_i),
    .last_i (gidx_q),
    .gnt_o  (arb_gnt)
  );

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
      assign words[i] = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = IW'(i);
      end
    end
  end

  // The session owner is selected by the registered grant index, so a
  // requester dropping req mid-session does not disturb the data path.
  assign sel_valid = wr_valid_i[gidx_q];
  assign sel_last  = wr_last_i[gidx_q];
  assign sel_data  = words[gidx_q];

  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    gnt_d        = gnt_q;
    wr_ready_d   = '0;
    done_d       = '0;
    error_d      = 1'b0;
    word_count_d = word_count_q;
    load_d       = load_q;
    data_d       = data_q;
    sck_d        = 1'b0;
    last_d       = last_q;
    setup_d      = setup_q;
    tmo_d        = tmo_q;

    case (state_q)
      ST_IDLE: begin
        load_d = 1'b0;
        if (|req_i) begin
          gnt_d        = arb_gnt;
          gidx_d       = arb_idx;
          word_count_d = '0;
          load_d       = 1'b1;
          data_d       = '0;
          setup_d      = '0;
          state_d      = (SETUP_CYCLES > 1) ? ST_SETUP : ST_PRESENT;
        end
      end

      // PRESENT supplies the last setup cycle, so the first accept lands
      // SETUP_CYCLES cycles after load rises.
      ST_SETUP: begin
        if (int'(setup_q) >= SETUP_CYCLES - 2) begin
          state_d = ST_PRESENT;
        end else begin
          setup_d = setup_q + 1'b1;
        end
      end

      ST_PRESENT: begin
        if (sel_valid && !rom_loader_ack_i) begin
          if (word_count_q == CW'(MAX_WORDS)) begin
            error_d = 1'b1;
            load_d  = 1'b0;
            state_d = ST_FINISH;
          end else begin
            data_d     = sel_data;
            wr_ready_d = gnt_q;
            last_d     = sel_last;
            state_d    = ST_STROBE;
          end
        end
      end

      ST_STROBE: begin
        sck_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (rom_loader_ack_i) begin
          word_count_d = word_count_q + 1'b1;
          if (last_q) begin
            done_d  = gnt_q;
            load_d  = 1'b0;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_PRESENT;
          end
        end else if (int'(tmo_q) + 1 >= ACK_TIMEOUT) begin
          error_d = 1'b1;
          load_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_FINISH: begin
        load_d  = 1'b0;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gidx_q       <= IW'(NUM_REQ - 1);
      gnt_q        <= '0;
      wr_ready_q   <= '0;
      done_q       <= '0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= '0;
      load_q       <= 1'b0;
      data_q       <= '0;
      sck_q        <= 1'b0;
      last_q       <= 1'b0;
      setup_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      gnt_q        <= gnt_d;
      wr_ready_q   <= wr_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
      load_q       <= load_d;
      data_q       <= data_d;
      sck_q        <= sck_d;
      last_q       <= last_d;
      setup_q      <= setup_d;
      tmo_q        <= tmo_d;
    end
  end

  assign gnt_o             = gnt_q;
  assign wr_ready_o        = wr_ready_q;
  assign done_o            = done_q;
  assign error_o           = error_q;
  assign busy_o            = busy_q;
  assign word_count_o      = word_count_q;
  assign rom_loader_load_o = load_q;
  assign rom_loader_data_o = data_q;
  assign rom_loader_sck_o  = sck_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_loader_arbiter : session table plus a ROM-loader model with a
//                         word scoreboard. Rev 1.0
// ============================================================================
module tb_rom_loader_arbiter;

  localparam int DW = 16;
  localparam int MW = 4;
  localparam int AT = 255;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  wr_valid = '0;
  logic [1:0]  wr_last = '0;
  logic [31:0] wr_data = '0;
  logic        rom_ack = 1'b0;

  logic [1:0]  gnt, wr_ready, done;
  logic        error, busy, load, sck;
  logic [2:0]  word_count;
  logic [15:0] rdata;

  rom_loader_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(DW), .MAX_WORDS(MW), .ACK_TIMEOUT(AT), .SETUP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req), .gnt_o(gnt),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_last_i(wr_last),
    .wr_ready_o(wr_ready), .done_o(done), .error_o(error), .busy_o(busy),
    .word_count_o(word_count), .rom_loader_load_o(load), .rom_loader_data_o(rdata),
    .rom_loader_sck_o(sck), .rom_loader_ack_i(rom_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ROM-loader model: acks m_delay cycles after sck, holds ack m_hold cycles.
  int          m_delay = -1;
  int          m_hold = 1;
  int          sb_bad = 0;
  int          sb_empty = 0;
  int          ack_viol = 0;
  logic [15:0] sb [$];

  initial begin : loader_model
    int          timer;
    int          hold_left;
    bit          ack_now;
    logic [15:0] e;
    timer     = -1;
    hold_left = 0;
    forever begin
      @(negedge clk);
      ack_now = rom_ack;
      if (reset) begin
        rom_ack   = 1'b0;
        timer     = -1;
        hold_left = 0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) rom_ack = 1'b0;
        end
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            rom_ack   = 1'b1;
            hold_left = m_hold;
            timer     = -1;
          end
        end
        if (sck) begin
          if (ack_now) ack_viol++;
          if (sb.size() == 0) begin
            sb_empty++;
            $display("scoreboard: unexpected word %h", rdata);
          end else begin
            e = sb.pop_front();
            if (rdata !== e) begin
              sb_bad++;
              $display("scoreboard: sck data %h expected %h", rdata, e);
            end
          end
          if (m_delay == 0) begin
            rom_ack   = 1'b1;
            hold_left = m_hold;
          end else if (m_delay > 0) begin
            timer = m_delay;
          end
        end
      end
    end
  end

  function automatic logic [15:0] word_of(input int e, input int i, input int k);
    logic [15:0] t0 [3];
    t0 = '{16'hEA87, 16'hFFFF, 16'h0000};
    if (e == 0 && i == 0 && k < 3) return t0[k];
    return 16'((e * 16'h03D1) ^ (k * 16'h1357) ^ (i * 16'h5A5A) ^ 16'h2468);
  endfunction

  task automatic drive_word(input int e, input int i, input int k, input int n);
    wr_data[i*16 +: 16] = word_of(e, i, k);
    wr_last[i]          = (k == n - 1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    wr_valid = '0;
    wr_last  = '0;
    wr_data  = '0;
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] req;
    int         nwords;
    int         delay;
    int         hold;
    bit         rst_before;
    bit         drop_req;
    int         exp_idx;
    int         exp_cnt;
    int         exp_acc;
    bit         exp_done;
    bit         exp_err;
  } sess_t;

  task automatic run_session(input int e, input sess_t s);
    int         widx [2];
    int         acc, lc, rc, fs, ls, ec, nsck, wide, stray, vb, bb, eb;
    bit         fin, prev_sck;
    logic [1:0] eg;
    string      p;
    p  = $sformatf("s%0d_", e);
    eg = 2'b01 << s.exp_idx;
    if (s.rst_before) do_reset();
    m_delay = s.delay;
    m_hold  = s.hold;
    widx = '{0, 0};
    acc = 0; rc = -1; fs = -1; ls = -1; ec = -1;
    nsck = 0; wide = 0; stray = 0; fin = 1'b0; prev_sck = 1'b0;
    vb = ack_viol; bb = sb_bad; eb = sb_empty;
    for (int i = 0; i < 2; i++) drive_word(e, i, 0, s.nwords);
    req      = s.req;
    wr_valid = s.req;
    @(negedge clk);
    check({p, "gnt"}, gnt, eg);
    check({p, "busy"}, busy, 1);
    check({p, "load_rise"}, load, 1);
    check({p, "count_clear"}, word_count, 0);
    lc = cyc;
    if (s.drop_req) req = 2'b00;
    for (int t = 0; t < 2000 && !fin; t++) begin
      @(negedge clk);
      if ((wr_ready & ~eg) != 2'b00) stray++;
      if (sck) begin
        nsck++;
        if (fs < 0) fs = cyc;
        ls = cyc;
        if (prev_sck) wide++;
      end
      prev_sck = sck;
      if (wr_ready[s.exp_idx]) begin
        sb.push_back(word_of(e, s.exp_idx, widx[s.exp_idx]));
        acc++;
        if (rc < 0) rc = cyc;
        widx[s.exp_idx]++;
        if (widx[s.exp_idx] < s.nwords) drive_word(e, s.exp_idx, widx[s.exp_idx], s.nwords);
        else wr_valid[s.exp_idx] = 1'b0;
      end
      if (done != 2'b00 || error) begin
        fin = 1'b1;
        ec  = cyc;
        check({p, "done"}, done, s.exp_done ? eg : 2'b00);
        check({p, "error"}, error, s.exp_err);
        check({p, "load_fall"}, load, 0);
        check({p, "word_count"}, word_count, s.exp_cnt);
      end
    end
    check({p, "ended"}, fin, 1);
    check({p, "accepted"}, acc, s.exp_acc);
    check({p, "sck_pulses"}, nsck, s.exp_acc);
    check({p, "sb_left"}, sb.size(), 0);
    check({p, "sb_data"}, sb_bad - bb, 0);
    check({p, "sb_extra"}, sb_empty - eb, 0);
    check({p, "stray_ready"}, stray, 0);
    check({p, "sck_wide"}, wide, 0);
    check({p, "sck_during_ack"}, ack_viol - vb, 0);
    check({p, "first_ready_lat"}, rc - lc, SC);
    check({p, "sck_after_ready"}, fs - rc, 1);
    if (s.delay < 0) check({p, "timeout_lat"}, ec - ls, AT);
    @(negedge clk);
    check({p, "gnt_clear"}, gnt, 0);
    check({p, "busy_clear"}, busy, 0);
    check({p, "done_pulse"}, done, 0);
    check({p, "error_pulse"}, error, 0);
    req      = '0;
    wr_valid = '0;
    wr_last  = '0;
    @(negedge clk);
    check({p, "idle_load"}, load, 0);
  endtask

  sess_t tbl [7];

  initial begin : main
    int  k;
    int  nsck;
    bit  hit;
    //              req    n  dly hold rst drop idx cnt acc done err
    tbl[0] = '{2'b01, 3,  2, 1, 1'b0, 1'b0, 0, 3, 3, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 2,  1, 1, 1'b1, 1'b0, 0, 2, 2, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 1,  3, 2, 1'b0, 1'b0, 1, 1, 1, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 2,  1, 1, 1'b0, 1'b0, 0, 2, 2, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 1, -1, 1, 1'b0, 1'b0, 1, 0, 1, 1'b0, 1'b1};
    tbl[5] = '{2'b01, 5,  1, 1, 1'b0, 1'b0, 0, 4, 4, 1'b0, 1'b1};
    tbl[6] = '{2'b10, 3,  2, 5, 1'b0, 1'b1, 1, 3, 3, 1'b1, 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    check("rst_load", load, 0);
    check("rst_data", rdata, 0);
    check("rst_sck", sck, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 7; e++) run_session(e, tbl[e]);

    // Reset while the second word of a session is waiting for its ack.
    m_delay = 2;
    m_hold  = 1;
    k = 0; nsck = 0; hit = 1'b0;
    drive_word(7, 0, 0, 3);
    req      = 2'b01;
    wr_valid = 2'b01;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (wr_ready[0]) begin
        sb.push_back(word_of(7, 0, k));
        k++;
        drive_word(7, 0, k, 3);
      end
      if (sck) begin
        nsck++;
        if (nsck == 2) hit = 1'b1;
      end
    end
    check("mrst_reached_word2", hit, 1);
    check("mrst_pre_count", word_count, 1);
    check("mrst_pre_load", load, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_gnt", gnt, 0);
    check("mrst_wr_ready", wr_ready, 0);
    check("mrst_done", done, 0);
    check("mrst_error", error, 0);
    check("mrst_busy", busy, 0);
    check("mrst_word_count", word_count, 0);
    check("mrst_load", load, 0);
    check("mrst_data", rdata, 0);
    check("mrst_sck", sck, 0);
    req      = '0;
    wr_valid = '0;
    wr_last  = '0;
    @(negedge clk);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    run_session(8, '{2'b01, 2, 2, 1, 1'b0, 1'b0, 0, 2, 2, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
